// File: rtl/my_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO, an FSM serialises each byte on txd.
// Latency: a DATA store at edge E0 into an idle, empty block pops at E1; txd drops after E1; frame = 10 bit periods.
// Backpressure: none toward the Bridge; a push into a full FIFO (with no same-cycle pop) is dropped and sets sticky overflow.
//
// Ports:
//   clk, rstn      clock and synchronous active-low reset
//   wen            one-cycle write strobe from the Bridge
//   addr           byte address, only addr[3:2] decoded (0 DATA, 1 STATUS, 2 DIV, 3 reserved)
//   wdata          write data
//   rdata          combinational read data for the addressed register
//   txd            registered serial output, idle high
module my_uart_tx #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Register decode
    logic [1:0] sel;
    logic       push;
    logic       div_wr;
    logic       stat_wr;

    assign sel     = addr[3:2];
    assign push    = wen && (sel == 2'd0);
    assign stat_wr = wen && (sel == 2'd1);
    assign div_wr  = wen && (sel == 2'd2);

    // Bits of the bus that this block never looks at
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    // Control registers
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        ovf_q;
    logic        ovf_d;

    // Transmit FSM state
    state_t      state_q;
    logic [7:0]  shift_q;
    logic [15:0] period_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_cnt_q;
    logic        txd_q;
    logic        bit_end;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign bit_end    = (baud_q == (period_q - 16'd1));

    // The FSM takes a byte either when idle or exactly at the end of a stop
    // bit, which is what makes back-to-back frames gapless.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        div_d = div_q;
        if (div_wr) begin
            div_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
        end
    end

    // A rejected push outranks a clear arriving in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (stat_wr && wdata[3]) begin
            ovf_d = 1'b0;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            div_q    <= 16'(CLK_DIV);
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

    // Transmit FSM; txd is driven from a register so it is glitch-free.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            txd_q     <= 1'b1;
            shift_q   <= 8'd0;
            period_q  <= 16'(CLK_DIV);
            baud_q    <= 16'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        period_q  <= div_q;
                        baud_q    <= 16'd0;
                        bit_cnt_q <= 3'd0;
                        txd_q     <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_q  <= 16'd0;
                        txd_q   <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_q  <= 16'd0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            // Next data bit is the one about to shift into bit 0.
                            txd_q     <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_q <= 16'd0;
                        if (pop) begin
                            shift_q   <= mem_q[rd_ptr_q];
                            period_q  <= div_q;
                            bit_cnt_q <= 3'd0;
                            txd_q     <= 1'b0;
                            state_q   <= S_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign txd = txd_q;

    // Read mux
    logic [7:0] cnt8;
    logic       busy;

    assign cnt8 = 8'(count_q);
    assign busy = (state_q != S_IDLE);

    always_comb begin
        rdata = 32'd0;
        case (sel)
            2'd1: begin
                rdata[0]    = busy;
                rdata[1]    = fifo_full;
                rdata[2]    = fifo_empty;
                rdata[3]    = ovf_q;
                rdata[15:8] = cnt8;
            end
            2'd2:    rdata[15:0] = div_q;
            default: rdata = 32'd0;
        endcase
    end

endmodule
